// File: rtl/fp_pkg.sv
// Shared definitions for the FP add/sub result stage: status bit positions,
// rounding modes and the operand classification used by the override logic.
package fp_pkg;

    // Bit positions inside the 8-bit status word; unlisted bits are always 0.
    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_INVALID = 2;
    localparam int ST_HUGE    = 4;

    // Rounding mode encoding on in_rnd.
    typedef enum logic [2:0] {
        RND_RNE = 3'd0,
        RND_RTZ = 3'd1,
        RND_RUP = 3'd2,
        RND_RDN = 3'd3
    } rnd_mode_e;

    // Operand class derived from the exponent and fraction fields.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        SUBN = 3'd1,
        NORM = 3'd2,
        INF  = 3'd3,
        QNAN = 3'd4,
        SNAN = 3'd5
    } fp_class_e;

endpackage

// File: rtl/fp_operand_class.sv
// Combinational operand classifier: exponent/fraction fields -> fp_class_e.
// A NaN is quiet when the fraction MSB is set, signalling otherwise.
module fp_operand_class
    import fp_pkg::*;
#(
    parameter int P_EXP  = 5,
    parameter int P_FRAC = 10
) (
    input  logic [P_EXP-1:0]  exp,
    input  logic [P_FRAC-1:0] frac,
    output fp_class_e         cls
);

    // Decode the class from the all-ones / all-zeros exponent patterns.
    always_comb begin
        cls = NORM;
        if (&exp) begin
            if (frac == '0)
                cls = INF;
            else if (frac[P_FRAC-1])
                cls = QNAN;
            else
                cls = SNAN;
        end else if (exp == '0) begin
            cls = (frac == '0) ? ZERO : SUBN;
        end
    end

endmodule

// File: rtl/fp_addsub_result_stage.sv
// Registered result stage behind the FP add/sub datapath. Applies the
// NaN / Inf / overflow / signed-zero overrides to the raw adder result,
// encodes the status word and presents it on a valid/ready stream with
// one cycle of latency.
// Build option: define FP_ADDSUB_RESULT_SKID_EN for a 2-entry skid buffer
// with a registered in_ready; otherwise a single register with a
// combinational in_ready.
module fp_addsub_result_stage
    import fp_pkg::*;
#(
    parameter int P_EXP  = 5,
    parameter int P_FRAC = 10,
    parameter int P_WORD = 1 + P_EXP + P_FRAC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_rnd,
    input  logic              in_op,
    input  logic [P_WORD-1:0] in_a,
    input  logic [P_WORD-1:0] in_b,
    input  logic [P_WORD-1:0] in_z_raw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P_WORD-1:0] out_z,
    output logic [7:0]        out_status
);

    localparam logic [P_EXP-1:0]  EXP_ONES  = '1;
    localparam logic [P_FRAC-1:0] FRAC_ZERO = '0;
    localparam logic [P_FRAC-1:0] QNAN_FRAC = {1'b1, {(P_FRAC-1){1'b0}}};

    fp_class_e         a_cls;
    fp_class_e         b_cls;
    logic              a_sign;
    logic              b_eff;
    logic              eff_sub;
    logic              a_nan;
    logic              b_nan;
    logic              a_inf;
    logic              b_inf;
    logic [P_EXP-1:0]  zr_exp;
    logic [P_FRAC-1:0] zr_frac;
    logic [P_WORD-1:0] nxt_z;
    logic [7:0]        nxt_status;
    logic              accept;
    logic              xfer;

    fp_operand_class #(.P_EXP(P_EXP), .P_FRAC(P_FRAC)) u_class_a (
        .exp  (in_a[P_WORD-2 -: P_EXP]),
        .frac (in_a[P_FRAC-1:0]),
        .cls  (a_cls)
    );

    fp_operand_class #(.P_EXP(P_EXP), .P_FRAC(P_FRAC)) u_class_b (
        .exp  (in_b[P_WORD-2 -: P_EXP]),
        .frac (in_b[P_FRAC-1:0]),
        .cls  (b_cls)
    );

    assign a_sign  = in_a[P_WORD-1];
    assign b_eff   = in_b[P_WORD-1] ^ in_op;
    assign eff_sub = a_sign ^ b_eff;
    assign a_nan   = (a_cls == QNAN) || (a_cls == SNAN);
    assign b_nan   = (b_cls == QNAN) || (b_cls == SNAN);
    assign a_inf   = (a_cls == INF);
    assign b_inf   = (b_cls == INF);
    assign zr_exp  = in_z_raw[P_WORD-2 -: P_EXP];
    assign zr_frac = in_z_raw[P_FRAC-1:0];

    // Special-case override mux and status encode; first matching case wins.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        nxt_z      = in_z_raw;
        nxt_status = '0;
        if (a_nan || b_nan) begin
            nxt_z                  = {1'b0, EXP_ONES, QNAN_FRAC};
            nxt_status[ST_INVALID] = (a_cls == SNAN) || (b_cls == SNAN);
        end else if (a_inf && b_inf && eff_sub) begin
            nxt_z                  = {1'b0, EXP_ONES, QNAN_FRAC};
            nxt_status[ST_INVALID] = 1'b1;
        end else if (a_inf || b_inf) begin
            nxt_z              = {(a_inf ? a_sign : b_eff), EXP_ONES, FRAC_ZERO};
            nxt_status[ST_INF] = 1'b1;
        end else if (zr_exp == EXP_ONES) begin
            nxt_z               = {in_z_raw[P_WORD-1], EXP_ONES, FRAC_ZERO};
            nxt_status[ST_INF]  = 1'b1;
            nxt_status[ST_HUGE] = 1'b1;
        end else if ((zr_exp == '0) && (zr_frac == '0)) begin
            nxt_z               = '0;
            nxt_z[P_WORD-1]     = (a_sign == b_eff) ? a_sign : (in_rnd == RND_RDN);
            nxt_status[ST_ZERO] = 1'b1;
        end
    end

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

`ifdef FP_ADDSUB_RESULT_SKID_EN

    logic              skid_full;
    logic [P_WORD-1:0] skid_z;
    logic [7:0]        skid_status;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready = ~skid_full;

    // Main register plus skid entry: new beats park in the skid when the main slot stalls.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_z       <= '0;
            out_status  <= '0;
            skid_full   <= 1'b0;
            skid_z      <= '0;
            skid_status <= '0;
        end else if (skid_full) begin
            if (xfer) begin
                out_z      <= skid_z;
                out_status <= skid_status;
                if (accept) begin
                    skid_z      <= nxt_z;
                    skid_status <= nxt_status;
                end else begin
                    skid_full <= 1'b0;
                end
            end
        end else if (accept) begin
            if (!out_valid || xfer) begin
                out_valid  <= 1'b1;
                out_z      <= nxt_z;
                out_status <= nxt_status;
            end else begin
                skid_full   <= 1'b1;
                skid_z      <= nxt_z;
                skid_status <= nxt_status;
            end
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

`else

    // Single register: ready whenever the slot is empty or being drained this cycle.
    assign in_ready = ~out_valid | out_ready;

    // Load on accept (also covers reload during a transfer); clear valid on a bare transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_z      <= '0;
            out_status <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_z      <= nxt_z;
            out_status <= nxt_status;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_fp_addsub_result_stage.sv
// Scoreboard bench for fp_addsub_result_stage: directed special-case
// vectors, an 8-beat stream with a toggling out_ready, and a mid-stream reset.
module tb_fp_addsub_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rnd;
    logic        in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_z_raw;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic [7:0]  out_status;

    fp_addsub_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rnd     (in_rnd),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_z_raw   (in_z_raw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_status (out_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] zr;
        logic        op;
        logic [2:0]  rnd;
        logic [15:0] ez;
        logic [7:0]  es;
    } vec_t;

    typedef struct {
        logic [15:0] ez;
        logic [7:0]  es;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t dir[10];
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   cyc      = 0;
    int   n_popped = 0;
    bit   took;
    bit   lat_chk;
    logic [15:0] cur_ez;
    logic [7:0]  cur_es;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Called after inputs are driven on the falling edge: samples, scores, then crosses one rising edge.
    task automatic cycle();
        exp_t e;
        #1;
        took = 1'b0;
`ifdef FP_ADDSUB_RESULT_SKID_EN
        if (rst_n && sb.size() <= 1)
            check("in_ready_skid_empty", {31'b0, in_ready}, 32'd1);
`endif
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                n_popped++;
                check("out_z", {16'b0, out_z}, {16'b0, e.ez});
                check("out_status", {24'b0, out_status}, {24'b0, e.es});
                if (lat_chk)
                    check("latency", cyc - e.cyc, 32'd1);
            end
        end
        if (rst_n && in_valid && in_ready) begin
            e.ez  = cur_ez;
            e.es  = cur_es;
            e.cyc = cyc;
            sb.push_back(e);
            took = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input vec_t v);
        in_a     = v.a;
        in_b     = v.b;
        in_z_raw = v.zr;
        in_op    = v.op;
        in_rnd   = v.rnd;
        cur_ez   = v.ez;
        cur_es   = v.es;
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] zr,
                                input logic op, input logic [2:0] rnd,
                                input logic [15:0] ez, input logic [7:0] es);
        vec_t v;
        v.a = a; v.b = b; v.zr = zr; v.op = op; v.rnd = rnd; v.ez = ez; v.es = es;
        return v;
    endfunction

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (sb.size() != 0 && budget < 50) begin
            cycle();
            budget++;
        end
        if (sb.size() != 0)
            check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        int idx;
        int budget;
        vec_t v;

        dir[0] = mk(16'h3C00, 16'h4000, 16'h4200, 1'b0, 3'd0, 16'h4200, 8'h00); // 1.0 + 2.0
        dir[1] = mk(16'h7C00, 16'h7C00, 16'h7E00, 1'b1, 3'd0, 16'h7E00, 8'h04); // +Inf - +Inf
        dir[2] = mk(16'h7BFF, 16'h7BFF, 16'h7C01, 1'b0, 3'd0, 16'h7C00, 8'h12); // overflow
        dir[3] = mk(16'h3C00, 16'h3C00, 16'h0000, 1'b1, 3'd3, 16'h8000, 8'h01); // x-x, rnd -Inf
        dir[4] = mk(16'h3C00, 16'h3C00, 16'h0000, 1'b1, 3'd0, 16'h0000, 8'h01); // x-x, RNE
        dir[5] = mk(16'h7D00, 16'h3C00, 16'h7D00, 1'b0, 3'd0, 16'h7E00, 8'h04); // sNaN + 1.0
        dir[6] = mk(16'h7E01, 16'h3C00, 16'h7E01, 1'b0, 3'd0, 16'h7E00, 8'h00); // qNaN + 1.0
        dir[7] = mk(16'h3C00, 16'h7C00, 16'h7C00, 1'b0, 3'd0, 16'h7C00, 8'h02); // 1.0 + +Inf
        dir[8] = mk(16'h3C00, 16'h7C00, 16'hFC00, 1'b1, 3'd0, 16'hFC00, 8'h02); // 1.0 - +Inf
        dir[9] = mk(16'h8000, 16'h8000, 16'h0000, 1'b0, 3'd0, 16'h8000, 8'h01); // -0 + -0

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        lat_chk   = 1'b0;
        drive(dir[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_z", {16'b0, out_z}, 32'd0);
        check("rst_out_status", {24'b0, out_status}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, one at a time with the consumer always ready.
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(dir[i]);
            in_valid = 1'b1;
            budget   = 0;
            took     = 1'b0;
            while (!took && budget < 20) begin
                cycle();
                budget++;
            end
            if (!took)
                check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            cycle();
        end
        drain();
        lat_chk = 1'b0;

        // Back-to-back stream with out_ready toggling every cycle.
        n_popped  = 0;
        idx       = 0;
        budget    = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        while (idx < 8 && budget < 100) begin
            v = mk(16'h3C00 + 16'(idx), 16'h4000, 16'h4200 + 16'(idx * 3), 1'b0, 3'd0,
                   16'h4200 + 16'(idx * 3), 8'h00);
            drive(v);
            out_ready = ~out_ready;
            cycle();
            if (took)
                idx++;
            budget++;
        end
        if (idx != 8)
            check("stream_accept_timeout", idx, 32'd8);
        drain();
        check("stream_count", n_popped, 32'd8);

        // Reset with beats held inside the stage: they must be discarded.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v = mk(16'h4400, 16'h4400, 16'h4800 + 16'(i), 1'b0, 3'd0, 16'h4800 + 16'(i), 8'h00);
            drive(v);
            cycle();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        cycle();
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            cycle();
            check("post_rst_idle", {31'b0, out_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
